// File: rtl/ex_sorter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_sorter_pkg
// Description : Shared constants and types for the sorter back end. A group
//               is the 4-element tuple produced by the sorting unit.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef EX_SORTER_NBITS
`define EX_SORTER_NBITS 8
`endif

package ex_sorter_pkg;

    localparam int c_nelems = 4;
    localparam int c_idx_w  = $clog2(c_nelems);

    // Default-width group type; parameterised modules build the same shape
    // from their own NBITS.
    typedef logic [c_nelems-1:0][`EX_SORTER_NBITS-1:0] ex_sorter_group_t;

endpackage : ex_sorter_pkg
`default_nettype wire

// File: rtl/ex_sorter_groupqueue.sv
`default_nettype none
// ============================================================================
// Module      : ex_sorter_groupqueue
// Description : Circular buffer of 4-element groups. Owns head/tail/count.
//               The caller decides when enqueue is legal; a simultaneous
//               enqueue and dequeue leaves count unchanged even when full.
// Ports       : clk, reset (sync, active-low)
//               enq_val/enq_bits - write a group at tail
//               deq_en           - retire the group at head
//               deq_bits         - group at head (valid when count != 0)
//               count, full      - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module ex_sorter_groupqueue
    import ex_sorter_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NGROUPS = 2,
    localparam int CNT_W  = $clog2(NGROUPS + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enq_val,
    input  logic [c_nelems-1:0][NBITS-1:0]   enq_bits,
    input  logic                             deq_en,
    output logic [c_nelems-1:0][NBITS-1:0]   deq_bits,
    output logic [CNT_W-1:0]                 count,
    output logic                             full
);

    localparam int c_ptr_w = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

    logic [c_nelems-1:0][NBITS-1:0] r_mem [NGROUPS];
    logic [c_ptr_w-1:0]             r_head;
    logic [c_ptr_w-1:0]             r_tail;
    logic [CNT_W-1:0]               r_count;
    logic [c_ptr_w-1:0]             w_head_nxt;
    logic [c_ptr_w-1:0]             w_tail_nxt;

    // Wrap by compare so any depth works, not just powers of two.
    always_comb begin
        w_head_nxt = (r_head == c_ptr_w'(NGROUPS - 1)) ? '0 : r_head + 1'b1;
        w_tail_nxt = (r_tail == c_ptr_w'(NGROUPS - 1)) ? '0 : r_tail + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (enq_val) r_tail <= w_tail_nxt;
            if (deq_en)  r_head <= w_head_nxt;
            case ({enq_val, deq_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        if (reset && enq_val) r_mem[r_tail] <= enq_bits;
    end

    assign deq_bits = r_mem[r_head];
    assign count    = r_count;
    assign full     = (r_count == CNT_W'(NGROUPS));

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (r_count <= CNT_W'(NGROUPS))
                else $error("groupqueue count %0d exceeds depth", r_count);
        end
    end
`endif

endmodule : ex_sorter_groupqueue
`default_nettype wire

// File: rtl/ex_sorter_sortedserializer.sv
`default_nettype none
// ============================================================================
// Module      : ex_sorter_sortedserializer
// Description : Captures sorted 4-tuples from the sorter into a group queue
//               and replays them one element per cycle (element 0 first) on
//               a val/rdy stream. Never back-pressures the sorter; exports
//               in_full for upstream throttling, flags drops and unsorted
//               groups with sticky bits.
// Ports       : clk, reset (sync, active-low)
//               in_val, in0..in3    - sorted group from the sorter
//               in_full             - queue holds NGROUPS groups
//               out_val/out_rdy     - output handshake
//               out_msg, out_last   - current element, last-of-group marker
//               ovfl, order_err     - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module ex_sorter_sortedserializer
    import ex_sorter_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NGROUPS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    input  logic [NBITS-1:0] in2,
    input  logic [NBITS-1:0] in3,
    output logic             in_full,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_msg,
    output logic             out_last,
    output logic             ovfl,
    output logic             order_err
);

    localparam int CNT_W = $clog2(NGROUPS + 1);

    logic [c_nelems-1:0][NBITS-1:0] w_enq_bits;
    logic [c_nelems-1:0][NBITS-1:0] w_deq_bits;
    logic [CNT_W-1:0]               w_count;
    logic                           w_full;
    logic                           w_fire;
    logic                           w_pop;
    logic                           w_enq;
    logic                           w_drop;
    logic                           w_sorted;
    logic [c_idx_w-1:0]             r_idx;
    logic                           r_ovfl;
    logic                           r_order_err;

    assign w_enq_bits = {in3, in2, in1, in0};

    // out_val comes only from registered count, so no path from out_rdy.
    assign out_val  = (w_count != '0);
    assign w_fire   = out_val && out_rdy;
    assign w_pop    = w_fire && (r_idx == c_idx_w'(c_nelems - 1));
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign w_enq    = in_val && (!w_full || w_pop);
    assign w_drop   = in_val && w_full && !w_pop;
    assign w_sorted = (in0 <= in1) && (in1 <= in2) && (in2 <= in3);

    ex_sorter_groupqueue #(
        .NBITS   (NBITS),
        .NGROUPS (NGROUPS)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (w_enq),
        .enq_bits (w_enq_bits),
        .deq_en   (w_pop),
        .deq_bits (w_deq_bits),
        .count    (w_count),
        .full     (w_full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx       <= '0;
            r_ovfl      <= 1'b0;
            r_order_err <= 1'b0;
        end else begin
            // idx is exactly log2(c_nelems) bits, so 3 -> 0 wraps naturally.
            if (w_fire) r_idx <= r_idx + 1'b1;
            if (w_drop) r_ovfl <= 1'b1;
            if (w_enq && !w_sorted) r_order_err <= 1'b1;
        end
    end

    assign out_msg   = out_val ? w_deq_bits[r_idx] : '0;
    assign out_last  = out_val && (r_idx == c_idx_w'(c_nelems - 1));
    assign in_full   = w_full;
    assign ovfl      = r_ovfl;
    assign order_err = r_order_err;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(in_val))  else $error("in_val is X");
            assert (!$isunknown(out_rdy)) else $error("out_rdy is X");
        end
    end
`endif

endmodule : ex_sorter_sortedserializer
`default_nettype wire

// File: tb/tb_ex_sorter_sortedserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_sorter_sortedserializer
// Description : Directed self-checking bench for ex_sorter_sortedserializer
//               (NBITS=8, NGROUPS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_sorter_sortedserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic [7:0] in0, in1, in2, in3;
    logic       in_full;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_msg;
    logic       out_last;
    logic       ovfl;
    logic       order_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_sorter_sortedserializer #(
        .NBITS   (8),
        .NGROUPS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in_full   (in_full),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .out_last  (out_last),
        .ovfl      (ovfl),
        .order_err (order_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic grp(input logic v, input logic [7:0] a, b, c, d);
        in_val = v;
        in0 = a; in1 = b; in2 = c; in3 = d;
    endtask

    // Check the visible element and last flag in one call.
    task automatic chk_el(input string tag, input logic [7:0] m, input logic l);
        chk({tag, "_val"},  {31'd0, out_val},  32'd1);
        chk({tag, "_msg"},  {24'd0, out_msg},  {24'd0, m});
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_val"},  {31'd0, out_val},  32'd0);
        chk({tag, "_msg"},  {24'd0, out_msg},  32'd0);
        chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; out_rdy = 1'b0;
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick(); tick();
        chk_idle("rst");
        chk("rst_full",  {31'd0, in_full},   32'd0);
        chk("rst_ovfl",  {31'd0, ovfl},      32'd0);
        chk("rst_order", {31'd0, order_err}, 32'd0);
        reset = 1'b1;
        tick();
        chk_idle("idle");

        // Single group, sink always ready: t+1..t+4 then empty.
        out_rdy = 1'b1;
        grp(1'b1, 8'd1, 8'd3, 8'd5, 8'd7);
        tick();
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk_el("single0", 8'd1, 1'b0);
        tick(); chk_el("single1", 8'd3, 1'b0);
        tick(); chk_el("single2", 8'd5, 1'b0);
        tick(); chk_el("single3", 8'd7, 1'b1);
        tick(); chk_idle("single_end");

        // Back-pressure mid-group holds element 1.
        grp(1'b1, 8'd10, 8'd20, 8'd30, 8'd40);
        tick();
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk_el("bp0", 8'd10, 1'b0);
        tick(); chk_el("bp1", 8'd20, 1'b0);
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_el("bp_hold", 8'd20, 1'b0);
        end
        out_rdy = 1'b1;
        tick(); chk_el("bp2", 8'd30, 1'b0);
        tick(); chk_el("bp3", 8'd40, 1'b1);
        tick(); chk_idle("bp_end");

        // Fill and overflow with the sink stalled.
        out_rdy = 1'b0;
        grp(1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
        tick(); chk("fill1_full", {31'd0, in_full}, 32'd0);
        grp(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        tick(); chk("fill2_full", {31'd0, in_full}, 32'd1);
        chk("fill2_ovfl", {31'd0, ovfl}, 32'd0);
        grp(1'b1, 8'd9, 8'd9, 8'd9, 8'd9);
        tick();
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("drop_ovfl", {31'd0, ovfl},    32'd1);
        chk("drop_full", {31'd0, in_full}, 32'd1);
        chk_el("drain0", 8'd1, 1'b0);
        out_rdy = 1'b1;
        tick(); chk_el("drain1", 8'd2, 1'b0);
        tick(); chk_el("drain2", 8'd3, 1'b0);
        tick(); chk_el("drain3", 8'd4, 1'b1);
        tick(); chk_el("drain4", 8'd5, 1'b0);
        chk("drain_full", {31'd0, in_full}, 32'd0);
        tick(); chk_el("drain5", 8'd6, 1'b0);
        tick(); chk_el("drain6", 8'd7, 1'b0);
        tick(); chk_el("drain7", 8'd8, 1'b1);
        tick(); chk_idle("drain_end");
        chk("ovfl_sticky", {31'd0, ovfl}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("ovfl_clr", {31'd0, ovfl}, 32'd0);

        // Enqueue on the pop cycle while full.
        out_rdy = 1'b0;
        grp(1'b1, 8'd1, 8'd1, 8'd2, 8'd2);
        tick();
        grp(1'b1, 8'd3, 8'd3, 8'd4, 8'd4);
        tick();
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("pf_full", {31'd0, in_full}, 32'd1);
        out_rdy = 1'b1;
        tick(); tick(); tick();
        chk_el("pf_idx3", 8'd2, 1'b1);
        grp(1'b1, 8'd5, 8'd5, 8'd6, 8'd6);
        tick();
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("pf_still_full", {31'd0, in_full}, 32'd1);
        chk("pf_ovfl",       {31'd0, ovfl},    32'd0);
        chk_el("pf_g2_0", 8'd3, 1'b0);
        tick(); chk_el("pf_g2_1", 8'd3, 1'b0);
        tick(); chk_el("pf_g2_2", 8'd4, 1'b0);
        tick(); chk_el("pf_g2_3", 8'd4, 1'b1);
        tick(); chk_el("pf_g3_0", 8'd5, 1'b0);
        chk("pf_g3_full", {31'd0, in_full}, 32'd0);
        tick(); chk_el("pf_g3_1", 8'd5, 1'b0);
        tick(); chk_el("pf_g3_2", 8'd6, 1'b0);
        tick(); chk_el("pf_g3_3", 8'd6, 1'b1);
        tick(); chk_idle("pf_end");

        // Unsorted group: flagged but still replayed verbatim.
        chk("ord_pre", {31'd0, order_err}, 32'd0);
        grp(1'b1, 8'd4, 8'd2, 8'd6, 8'd8);
        tick();
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("ord_set", {31'd0, order_err}, 32'd1);
        chk_el("ord0", 8'd4, 1'b0);
        tick(); chk_el("ord1", 8'd2, 1'b0);
        tick(); chk_el("ord2", 8'd6, 1'b0);
        tick(); chk_el("ord3", 8'd8, 1'b1);
        tick(); chk_idle("ord_end");
        chk("ord_sticky", {31'd0, order_err}, 32'd1);

        // Reset while element 2 of a group is showing.
        grp(1'b1, 8'd11, 8'd12, 8'd13, 8'd14);
        tick();
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick(); tick();
        chk_el("rm_idx2", 8'd13, 1'b0);
        reset = 1'b0;
        grp(1'b1, 8'd99, 8'd1, 8'd1, 8'd1);
        tick();
        reset = 1'b1;
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk_idle("rm");
        chk("rm_full",  {31'd0, in_full},   32'd0);
        chk("rm_ovfl",  {31'd0, ovfl},      32'd0);
        chk("rm_order", {31'd0, order_err}, 32'd0);
        grp(1'b1, 8'd21, 8'd22, 8'd23, 8'd24);
        tick();
        grp(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk_el("rm_new0", 8'd21, 1'b0);
        tick(); chk_el("rm_new1", 8'd22, 1'b0);
        tick(); chk_el("rm_new2", 8'd23, 1'b0);
        tick(); chk_el("rm_new3", 8'd24, 1'b1);
        tick(); chk_idle("rm_end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ex_sorter_sortedserializer
`default_nettype wire
